// File: rtl/fifo_ctrl_sync_if.sv
// Control bundle between a FIFO user and the fifo_ctrl_sync pointer controller.
// The master side issues requests; the slave side (the controller) returns
// accepts, RAM addresses, pointers, occupancy and status flags.
interface fifo_ctrl_sync_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic                  rd_en;
  logic                  flush;
  logic                  err_clr;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, rd_en, flush, err_clr,
    input  wr_accept, rd_accept, wr_addr, rd_addr, wr_ptr, rd_ptr, count,
           full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en, flush, err_clr,
    output wr_accept, rd_accept, wr_addr, rd_addr, wr_ptr, rd_ptr, count,
           full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_sync.sv
// Single-clock FIFO pointer controller for an external dual-port RAM.
// Tracks write/read pointers (with wrap bit), occupancy, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// synchronous flush. Reset is asynchronous, active-low.
module fifo_ctrl_sync #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_THRESH  = 14,
  parameter int unsigned AE_THRESH  = 2
) (
  input logic              clk,
  input logic              rst,
  fifo_ctrl_sync_if.slave  bus
);
  localparam int unsigned         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [ADDR_WIDTH:0] wr_ptr_q;
  logic [ADDR_WIDTH:0] rd_ptr_q;
  logic [ADDR_WIDTH:0] count_q;
  logic                overflow_q;
  logic                underflow_q;

  logic full_c;
  logic empty_c;
  logic wr_acc_c;
  logic rd_acc_c;
  logic ovf_set_c;
  logic unf_set_c;

  // Status decode and request qualification from registered state.
  always_comb begin
    full_c    = (count_q == DEPTH_C);
    empty_c   = (count_q == '0);
    wr_acc_c  = bus.wr_en & ~full_c  & ~bus.flush;
    rd_acc_c  = bus.rd_en & ~empty_c & ~bus.flush;
    ovf_set_c = bus.wr_en & full_c  & ~bus.flush;
    unf_set_c = bus.rd_en & empty_c & ~bus.flush;
  end

  // Pointer and occupancy registers; flush overrides any accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_acc_c) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc_c) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_acc_c && !rd_acc_c)      count_q <= count_q + 1'b1;
      else if (rd_acc_c && !wr_acc_c) count_q <= count_q - 1'b1;
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ovf_set_c)        overflow_q  <= 1'b1;
      else if (bus.err_clr) overflow_q  <= 1'b0;
      if (unf_set_c)        underflow_q <= 1'b1;
      else if (bus.err_clr) underflow_q <= 1'b0;
    end
  end

  assign bus.wr_accept    = wr_acc_c;
  assign bus.rd_accept    = rd_acc_c;
  assign bus.wr_addr      = wr_ptr_q[ADDR_WIDTH-1:0];
  assign bus.rd_addr      = rd_ptr_q[ADDR_WIDTH-1:0];
  assign bus.wr_ptr       = wr_ptr_q;
  assign bus.rd_ptr       = rd_ptr_q;
  assign bus.count        = count_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// Testbench for fifo_ctrl_sync: directed boundary sequences followed by
// randomized traffic, all compared against a queue-based FIFO model.
module tb_fifo_ctrl_sync;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_ctrl_sync_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_ctrl_sync #(
    .ADDR_WIDTH(AW),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue contents, total accepted writes/reads since
  // reset or flush, sticky error bits.
  int m_q[$];
  int m_wr  = 0;
  int m_rd  = 0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  int m_seq = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wr  = 0;
    m_rd  = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic check_state();
    int n;
    n = m_q.size();
    check("count",        bus.count,        n);
    check("full",         bus.full,         (n == DEPTH));
    check("empty",        bus.empty,        (n == 0));
    check("almost_full",  bus.almost_full,  (n >= AF));
    check("almost_empty", bus.almost_empty, (n <= AE));
    check("overflow",     bus.overflow,     m_ovf);
    check("underflow",    bus.underflow,    m_unf);
    check("wr_ptr",       bus.wr_ptr,       m_wr % (2*DEPTH));
    check("rd_ptr",       bus.rd_ptr,       m_rd % (2*DEPTH));
    check("wr_addr",      bus.wr_addr,      m_wr % DEPTH);
    check("rd_addr",      bus.rd_addr,      m_rd % DEPTH);
    check("ptr_diff",     (32'(bus.wr_ptr) - 32'(bus.rd_ptr)) & 32'h1f, n);
  endtask

  // One clock cycle: drive requests after the falling edge, check the
  // combinational accepts and the current state, then advance the model.
  task automatic step(input bit w, input bit r, input bit f, input bit e);
    bit exp_wa, exp_ra;
    int n;
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.flush   = f;
    bus.err_clr = e;
    #1;
    n      = m_q.size();
    exp_wa = w && (n != DEPTH) && !f;
    exp_ra = r && (n != 0) && !f;
    check("wr_accept", bus.wr_accept, exp_wa);
    check("rd_accept", bus.rd_accept, exp_ra);
    check_state();
    @(posedge clk);
    if (w && n == DEPTH && !f) m_ovf = 1'b1;
    else if (e)                m_ovf = 1'b0;
    if (r && n == 0 && !f)     m_unf = 1'b1;
    else if (e)                m_unf = 1'b0;
    if (f) begin
      m_q.delete();
      m_wr = 0;
      m_rd = 0;
    end else begin
      if (exp_ra) begin
        void'(m_q.pop_front());
        m_rd++;
      end
      if (exp_wa) begin
        m_q.push_back(m_seq++);
        m_wr++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
    model_reset();

    // Reset held for three cycles with a write pending.
    repeat (3) @(negedge clk);
    #1;
    check_state();
    rst       = 1'b1;
    bus.wr_en = 1'b0;

    // Fill to full, then overflow and error-clear interplay.
    repeat (DEPTH) step(1, 0, 0, 0);
    check("fill_wr_ptr", bus.wr_ptr, 32'h10);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    check("ovf_cleared", bus.overflow, 0);

    // Simultaneous at full, drain, simultaneous at empty.
    step(1, 1, 0, 0);
    check("full_both_count", bus.count, DEPTH - 1);
    repeat (DEPTH - 1) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("empty_both_unf", bus.underflow, 1);
    step(0, 0, 0, 1);

    // Steady-state wrap-around at occupancy 3.
    repeat (2) step(1, 0, 0, 0);
    repeat (40) step(1, 1, 0, 0);
    check("wrap_count", bus.count, 3);

    // Flush with a pending write, then threshold edges on refill.
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (7) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    check("flush_empty", bus.empty, 1);
    repeat (3) step(1, 0, 0, 0);
    check("ae_at_3", bus.almost_empty, 0);

    // Asynchronous reset asserted between clock edges.
    repeat (4) step(1, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_state();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic with varying write/read bias.
    for (int blk = 0; blk < 12; blk++) begin
      int pw, pr;
      pw = $urandom_range(20, 90);
      pr = $urandom_range(20, 90);
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 99) < pw,
             $urandom_range(0, 99) < pr,
             $urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < 5);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
